fwd_ctrl: RTL
=============

FWD_CTRL -- requirements
Module: fwd_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 4, total EX-stage cycles for one multiply (legal 2..15).
REQ-002 clk_i  input  1  single clock; every register updates on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 id_valid_i  input  1  the ID stage holds a real instruction.
REQ-005 id_rs_i, id_rt_i  input  5 each  source registers of the ID instruction.
REQ-006 id_rd_i  input  5  destination register of the ID instruction.
REQ-007 id_regwrite_i, id_memread_i  input  1 each  the ID instruction writes a register / is a load.
REQ-008 id_mul_i  input  1  the ID instruction is a multiply; present only with MULDIV_STALL_EN.
REQ-009 flush_i  input  1  taken branch; discard the ID instruction.
REQ-010 fw_a_o, fw_b_o  output  2 each  forwarding selects for EX operands A and B: 00 register-file data, 01 WB result, 10 EX/MEM ALU result.
REQ-011 stall_o  output  1  hold PC and IF/ID this cycle.
REQ-012 stall_cnt_o  output  16  saturating count of cycles with stall_o=1.

Function
REQ-013 Internal shadow entries EX, MEM, WB each SHALL hold valid, rs, rt, rd, regwrite, memread.
REQ-014 On each edge: WB<=MEM; MEM<=EX, or a bubble while a multiply is still busy; EX<=ID if id_valid_i=1, stall_o=0, flush_i=0 and no multiply is busy; otherwise EX<=bubble, except that EX holds its contents while a multiply is busy.
REQ-015 fw_a_o SHALL be 10 if MEM.valid, MEM.regwrite, MEM.rd!=0 and MEM.rd==EX.rs; else 01 under the same test against WB; else 00. fw_b_o SHALL use the same test with EX.rt.
REQ-016 fw_*_o SHALL be 00 whenever EX is a bubble; register 0 is never forwarded.
REQ-017 Load-use: stall_o=1 combinationally when id_valid_i, EX.valid, EX.memread, EX.regwrite, EX.rd!=0 and EX.rd is in {id_rs_i, id_rt_i}; this lasts exactly one cycle, because EX becomes a bubble.
REQ-018 flush_i=1 SHALL force stall_o=0 and a bubble into EX in that cycle; flush has priority over load-use.
REQ-019 stall_cnt_o SHALL increment on every edge where stall_o=1 and hold at 16'hFFFF.
REQ-020 Latency: forwarding selects and stall_o are valid in the same cycle as their inputs; there is no output register.

Reset
REQ-021 While rst_i=0, all shadow entries SHALL be invalid with zero fields, the multiply counter SHALL be 0 and stall_cnt_o SHALL be 0.
REQ-022 Consequently fw_a_o=fw_b_o=00 and stall_o=0 during reset and in the first cycle after it.
REQ-023 Reset asserted mid-multiply or mid-stall SHALL abort immediately, with no residual stall after release.

Configuration
REQ-024 Macro MULDIV_STALL_EN SHALL compile in id_mul_i and a 4-bit busy counter.
REQ-025 With MULDIV_STALL_EN: a multiply entering EX loads the counter with MUL_LAT-1.
  - While the counter is nonzero, EX holds, MEM takes bubbles, stall_o=1 and the counter decrements.
  - The multiply advances to MEM on the edge where the counter reaches 0, so stall_o is high for MUL_LAT-1 cycles.
  - flush_i SHALL NOT abort a multiply already in EX.
REQ-026 Without MULDIV_STALL_EN: the id_mul_i port and the counter are absent, and multiplies behave as single-cycle ALU operations.

Verification
REQ-027 Issue add r3 (rd=3), then sub with rs=3 -> for sub in EX: fw_a_o=10; with one independent instruction in between: fw_a_o=01.
REQ-028 Issue lw r5, then add with rt=5 -> stall_o=1 for exactly 1 cycle, then fw_b_o=01, and stall_cnt_o increments by 1.
REQ-029 Issue add r0 from r1, then an instruction with rs=0 -> fw_a_o=00.
REQ-030 Apply load-use hazard and flush_i=1 in the same cycle -> stall_o=0, EX becomes a bubble, fw outputs 00 in the next cycle.
REQ-031 With MULDIV_STALL_EN and MUL_LAT=4, issue mul r7, then an instruction reading r7 -> stall_o=1 for 3 cycles, then fw_a_o=10.
REQ-032 Drive rst_i=0 during the 2nd mul stall cycle, then release -> stall_o=0, fw outputs 00 and stall_cnt_o=0 immediately.

Source files
------------

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: forwarding and hazard control for a 5-stage in-order pipeline.
// Keeps EX/MEM/WB shadow copies of issued instructions and derives
// operand forwarding selects, load-use stalls and a saturating stall count.
// Ports:
//   clk_i, rst_i (async, active-low)
//   id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_regwrite_i, id_memread_i
//   id_mul_i (only with MULDIV_STALL_EN), flush_i
//   fw_a_o, fw_b_o (00 regfile, 01 WB, 10 EX/MEM), stall_o, stall_cnt_o
// Option: define MULDIV_STALL_EN to hold multiplies in EX for MUL_LAT cycles.
module fwd_ctrl #(
   parameter int MUL_LAT = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        id_valid_i,
   input  logic [4:0]  id_rs_i,
   input  logic [4:0]  id_rt_i,
   input  logic [4:0]  id_rd_i,
   input  logic        id_regwrite_i,
   input  logic        id_memread_i,
`ifdef MULDIV_STALL_EN
   input  logic        id_mul_i,
`endif
   input  logic        flush_i,
   output logic [1:0]  fw_a_o,
   output logic [1:0]  fw_b_o,
   output logic        stall_o,
   output logic [15:0] stall_cnt_o
);

   typedef struct packed {
      logic       v;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic       rw;
      logic       mr;
   } ent_t;

   ent_t        r_ex;
   ent_t        r_mem;
   ent_t        r_wb;
   ent_t        w_id;
   logic [15:0] r_stall_cnt;
   logic        w_busy;
   logic        w_lu;
   logic        w_stall;
   logic        w_adv;
   logic        w_unused;

   assign w_id = '{v: id_valid_i, rs: id_rs_i, rt: id_rt_i,
                   rd: id_rd_i, rw: id_regwrite_i, mr: id_memread_i};

`ifdef MULDIV_STALL_EN
   logic [3:0] r_mul_cnt;

   assign w_busy = (r_mul_cnt != 4'd0);

   // Counter is loaded as the multiply enters EX; EX is frozen until it
   // drains, giving MUL_LAT total EX cycles.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_mul_cnt <= 4'd0;
      end else if (w_busy) begin
         r_mul_cnt <= r_mul_cnt - 4'd1;
      end else if (w_adv && id_mul_i) begin
         r_mul_cnt <= 4'(MUL_LAT - 1);
      end
   end
`else
   assign w_busy = 1'b0;
`endif

   // Load in EX whose result an ID source needs: one bubble resolves it.
   assign w_lu = id_valid_i && r_ex.v && r_ex.mr && r_ex.rw &&
                 (r_ex.rd != 5'd0) &&
                 ((r_ex.rd == id_rs_i) || (r_ex.rd == id_rt_i));

   // A taken branch discards ID, so holding it would be pointless.
   assign w_stall = !flush_i && (w_lu || w_busy);
   assign w_adv   = id_valid_i && !w_stall && !flush_i && !w_busy;

   always_comb begin
      fw_a_o = 2'b00;
      fw_b_o = 2'b00;
      if (r_ex.v) begin
         if (r_mem.v && r_mem.rw && r_mem.rd != 5'd0 && r_mem.rd == r_ex.rs)
            fw_a_o = 2'b10;
         else if (r_wb.v && r_wb.rw && r_wb.rd != 5'd0 && r_wb.rd == r_ex.rs)
            fw_a_o = 2'b01;
         if (r_mem.v && r_mem.rw && r_mem.rd != 5'd0 && r_mem.rd == r_ex.rt)
            fw_b_o = 2'b10;
         else if (r_wb.v && r_wb.rw && r_wb.rd != 5'd0 && r_wb.rd == r_ex.rt)
            fw_b_o = 2'b01;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_ex        <= '0;
         r_mem       <= '0;
         r_wb        <= '0;
         r_stall_cnt <= 16'd0;
      end else begin
         r_wb  <= r_mem;
         r_mem <= w_busy ? '0 : r_ex;
         if (!w_busy)
            r_ex <= w_adv ? w_id : '0;
         if (w_stall && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_o     = w_stall;
   assign stall_cnt_o = r_stall_cnt;

   // Fields kept for completeness of the shadow entries but not consumed.
   assign w_unused = ^{r_mem.rs, r_mem.rt, r_mem.mr,
                       r_wb.rs, r_wb.rt, r_wb.mr, 32'(MUL_LAT)};

endmodule
